// File: rtl/cordic_result_collector.sv
// Receive-side collector for the CORDIC wrapper: strips each 56-bit word to its
// 54-bit result, buffers it in a small FIFO and tracks frame count/overflow.
module cordic_result_collector #(
  parameter int INPUT_DATA_WIDTH  = 49,
  parameter int OUTPUT_DATA_WIDTH = 54,
  parameter int DATA_WIDTH        = 56,
  parameter int FIFO_DEPTH        = 8,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_en,
  input  logic [INPUT_DATA_WIDTH-1:0]  i_stop_code,
  input  logic                         i_vld,
  input  logic [DATA_WIDTH-1:0]        i_data,
  output logic                         o_vld,
  output logic [OUTPUT_DATA_WIDTH-1:0] o_data,
  output logic                         o_last,
  input  logic                         i_rdy,
  output logic [CNT_WIDTH-1:0]         o_count,
  output logic                         o_overflow,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = OUTPUT_DATA_WIDTH + 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               state;
  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          occ;
  logic [AW:0]          occ_nxt;
  logic [CNT_WIDTH-1:0] count;
  logic                 overflow;
  logic                 busy;
  logic                 done;

  logic                 is_stop_p0;
  logic [EW-1:0]        entry_p0;
  logic                 vld_p0;
  logic                 pop;
  logic                 room;
  logic                 push;
  logic                 drop;
  logic                 unused_hi;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  // Stage p0: decode the incoming wrapper word (guard bits above the payload are dropped)
  assign unused_hi  = ^i_data[DATA_WIDTH-1:OUTPUT_DATA_WIDTH];
  assign is_stop_p0 = (i_data[INPUT_DATA_WIDTH-1:0] == i_stop_code);
  assign entry_p0   = {is_stop_p0, i_data[OUTPUT_DATA_WIDTH-1:0]};
  assign vld_p0     = (state == S_COLLECT) && i_vld;

  assign o_vld   = (occ != '0);
  assign pop     = o_vld && i_rdy;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept a push.
  assign room    = (occ != DEPTH_C) || pop;
  assign push    = vld_p0 && room;
  assign drop    = vld_p0 && !room;
  assign occ_nxt = occ + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  // Stage p1: FIFO storage (data path, no reset)
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= entry_p0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      count    <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      occ <= occ_nxt;
      case (state)
        S_IDLE: begin
          if (i_en) begin
            state    <= S_COLLECT;
            busy     <= 1'b1;
            count    <= '0;
            overflow <= 1'b0;
          end
        end
        S_COLLECT: begin
          if (push && !is_stop_p0) count <= sat_inc(count);
          if (drop) overflow <= 1'b1;
          if ((i_vld && is_stop_p0) || !i_en) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (occ_nxt == '0) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          if (!i_en) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Head entry is gated so an empty FIFO always presents zeros.
  assign o_data     = o_vld ? mem[rd_ptr][OUTPUT_DATA_WIDTH-1:0] : '0;
  assign o_last     = o_vld && mem[rd_ptr][EW-1];
  assign o_count    = count;
  assign o_overflow = overflow;
  assign o_busy     = busy;
  assign o_done     = done;

endmodule

// File: tb/tb_cordic_result_collector.sv
// Directed bench for cordic_result_collector: expected results are queued at
// issue time and a forked monitor checks every word that leaves the FIFO.
module tb_cordic_result_collector;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_en;
  logic [48:0] i_stop_code;
  logic        i_vld;
  logic [55:0] i_data;
  logic        o_vld;
  logic [53:0] o_data;
  logic        o_last;
  logic        i_rdy;
  logic [3:0]  o_count;
  logic        o_overflow;
  logic        o_busy;
  logic        o_done;

  cordic_result_collector #(
    .INPUT_DATA_WIDTH (49),
    .OUTPUT_DATA_WIDTH(54),
    .DATA_WIDTH       (56),
    .FIFO_DEPTH       (8),
    .CNT_WIDTH        (4)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (i_en),
    .i_stop_code(i_stop_code),
    .i_vld      (i_vld),
    .i_data     (i_data),
    .o_vld      (o_vld),
    .o_data     (o_data),
    .o_last     (o_last),
    .i_rdy      (i_rdy),
    .o_count    (o_count),
    .o_overflow (o_overflow),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 i_clk = ~i_clk;

  logic [54:0] sb [$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [53:0] p, input logic exp_last, input bit keep);
    i_vld  = 1'b1;
    i_data = {2'b10, p};
    if (keep) sb.push_back({exp_last, p});
    tick();
    i_vld  = 1'b0;
    i_data = '0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!o_done && k < 50) begin
      tick();
      k++;
    end
    check("done_reached", {63'd0, o_done}, 64'd1);
  endtask

  task automatic monitor();
    logic [54:0] exp;
    forever begin
      @(negedge i_clk);
      if (o_vld && i_rdy) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got %0h expected nothing", {o_last, o_data});
        end else begin
          exp = sb.pop_front();
          check("out_word", {9'd0, o_last, o_data}, {9'd0, exp});
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    i_rst_n = 1'b0; i_en = 1'b0; i_stop_code = 49'h1_2345;
    i_vld = 1'b0; i_data = '0; i_rdy = 1'b1;
    fork
      monitor();
    join_none
    tick(); tick();
    check("rst_vld",   {63'd0, o_vld}, 64'd0);
    check("rst_data",  {10'd0, o_data}, 64'd0);
    check("rst_last",  {63'd0, o_last}, 64'd0);
    check("rst_busy",  {63'd0, o_busy}, 64'd0);
    check("rst_done",  {63'd0, o_done}, 64'd0);
    check("rst_count", {60'd0, o_count}, 64'd0);
    check("rst_ovf",   {63'd0, o_overflow}, 64'd0);
    i_rst_n = 1'b1;

    // Basic frame: 5 results then the stop word
    i_en = 1'b1; tick();
    check("f1_busy", {63'd0, o_busy}, 64'd1);
    for (int k = 1; k <= 5; k++) send(54'(k), 1'b0, 1'b1);
    send(54'h0_0001_2345, 1'b1, 1'b1);
    check("f1_last_head", {62'd0, o_vld, o_last}, 64'd3);
    check("f1_count", {60'd0, o_count}, 64'd5);
    check("f1_not_done", {63'd0, o_done}, 64'd0);
    tick();
    check("f1_done", {62'd0, o_done, o_vld}, 64'd2);
    i_en = 1'b0; tick();
    check("f1_idle", {62'd0, o_done, o_busy}, 64'd0);

    // Backpressure and overflow
    i_en = 1'b1; tick();
    i_rdy = 1'b0;
    for (int k = 1; k <= 8; k++) send(54'h100 + 54'(k), 1'b0, 1'b1);
    check("f2_ovf_at8", {63'd0, o_overflow}, 64'd0);
    send(54'h109, 1'b0, 1'b0);
    check("f2_ovf_at9", {63'd0, o_overflow}, 64'd1);
    send(54'h10A, 1'b0, 1'b0);
    check("f2_count", {60'd0, o_count}, 64'd8);
    check("f2_head", {10'd0, o_data}, 64'h101);
    i_en = 1'b0; tick();
    i_rdy = 1'b1;
    wait_done();
    tick();
    check("f2_idle", {62'd0, o_done, o_busy}, 64'd0);

    // Full FIFO with a simultaneous pop
    i_en = 1'b1; tick();
    check("f3_count_clr", {60'd0, o_count}, 64'd0);
    check("f3_ovf_clr", {63'd0, o_overflow}, 64'd0);
    i_rdy = 1'b0;
    for (int k = 1; k <= 8; k++) send(54'h300 + 54'(k), 1'b0, 1'b1);
    i_rdy = 1'b1;
    send(54'h309, 1'b0, 1'b1);
    check("f3_ovf_pushpop", {63'd0, o_overflow}, 64'd0);
    check("f3_count", {60'd0, o_count}, 64'd9);
    i_rdy = 1'b0;
    send(54'h30A, 1'b0, 1'b0);
    check("f3_still_full", {63'd0, o_overflow}, 64'd1);
    i_en = 1'b0; tick();
    i_rdy = 1'b1;
    wait_done();
    tick();

    // Abort without a stop word
    i_en = 1'b1; tick();
    check("f4_ovf_clr", {63'd0, o_overflow}, 64'd0);
    for (int k = 1; k <= 3; k++) send(54'h400 + 54'(k), 1'b0, 1'b1);
    i_en = 1'b0; tick();
    wait_done();
    tick();
    check("f4_idle", {62'd0, o_done, o_busy}, 64'd0);
    i_en = 1'b1; tick();
    check("f5_count_clr", {60'd0, o_count}, 64'd0);
    check("f5_ovf_clr", {63'd0, o_overflow}, 64'd0);

    // Reset with 4 entries buffered
    i_rdy = 1'b0;
    for (int k = 1; k <= 4; k++) send(54'h500 + 54'(k), 1'b0, 1'b1);
    check("f5_buffered", {63'd0, o_vld}, 64'd1);
    i_rst_n = 1'b0; tick();
    check("f5_rst_vld", {63'd0, o_vld}, 64'd0);
    check("f5_rst_count", {60'd0, o_count}, 64'd0);
    check("f5_rst_busy", {63'd0, o_busy}, 64'd0);
    check("f5_rst_data", {10'd0, o_data}, 64'd0);
    sb.delete();
    i_rst_n = 1'b1; i_en = 1'b0; i_rdy = 1'b1;
    repeat (3) tick();
    check("f5_no_stale", {63'd0, o_vld}, 64'd0);

    // Count saturation at 15 with 20 results; last word arrives with i_en low
    i_en = 1'b1; tick();
    for (int k = 1; k <= 19; k++) send(54'h600 + 54'(k), 1'b0, 1'b1);
    i_en = 1'b0;
    send(54'h614, 1'b0, 1'b1);
    check("f6_count_sat", {60'd0, o_count}, 64'd15);
    wait_done();
    tick();
    check("f6_idle", {62'd0, o_done, o_busy}, 64'd0);

    repeat (2) tick();
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
